// File: rtl/hypot_alu_param.sv
// Multi-cycle floor(sqrt(a^2+b^2)) / floor(sqrt(a)) unit; every add/subtract runs on the shared core ALU.
// Optional round-to-nearest result when HYPOT_ROUND_EN is defined.
module hypot_alu_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    input  logic [31:0]      resALU,
    output logic [2:0]       operationALU,
    output logic [31:0]      argA,
    output logic [31:0]      argB,
    output logic [WIDTH:0]   c_bo,
    output logic             busy_o,
    output logic             done_o
);
    localparam int XW = 2*WIDTH + 1;
    localparam logic [2:0]    OP_ADD  = 3'b000;
    localparam logic [2:0]    OP_SUB  = 3'b100;
    localparam logic [4:0]    LAST_SQ = 5'(WIDTH-1);
    localparam logic [4:0]    LAST_RT = 5'(WIDTH);
    localparam logic [XW-1:0] M0      = {1'b1, {(2*WIDTH){1'b0}}};
    localparam logic [WIDTH:0] ONE    = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SQ_A, SQ_B, SUM, SQRT, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [4:0]      cnt_q;
    logic [31:0]     a2_q, x_q;
    logic [XW-1:0]   r_q, m_q;

    logic [31:0]     bq, x_n;
    logic            ge;
    logic [XW-1:0]   r_n, m_n;
    logic [WIDTH:0]  c_fin;

    // Shift-add partial product: op<<i when bit i of the multiplier (op itself) is set.
    function automatic logic [31:0] pp(input logic [WIDTH-1:0] op, input logic [4:0] i);
        logic [31:0] w;
        w = 32'(op);
        return w[i] ? (w << i) : 32'd0;
    endfunction

    always_comb begin
        bq    = 32'(m_q) | 32'(r_q);
        ge    = x_q >= bq;
        x_n   = ge ? resALU : x_q;
        r_n   = ge ? ((r_q >> 1) | m_q) : (r_q >> 1);
        m_n   = m_q >> 2;
`ifdef HYPOT_ROUND_EN
        c_fin = (x_n > 32'(r_n)) ? r_n[WIDTH:0] + ONE : r_n[WIDTH:0];
`else
        c_fin = r_n[WIDTH:0];
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE);
        case (state_q)
            IDLE:    if (start_i) state_d = mode_i ? SQRT : SQ_A;
            SQ_A:    if (cnt_q == LAST_SQ) state_d = SQ_B;
            SQ_B:    if (cnt_q == LAST_SQ) state_d = SUM;
            SUM:     state_d = SQRT;
            SQRT:    if (cnt_q == LAST_RT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU operands are registered for the step that runs in the following cycle;
    // during squaring argA doubles as the accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            operationALU <= OP_ADD;
            argA         <= '0;
            argB         <= '0;
            c_bo         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            a2_q         <= '0;
            x_q          <= '0;
            r_q          <= '0;
            m_q          <= '0;
        end else begin
            operationALU <= OP_ADD;
            argA         <= '0;
            argB         <= '0;
            case (state_q)
                IDLE: if (start_i) begin
                    a_q   <= a_bi;
                    b_q   <= b_bi;
                    cnt_q <= '0;
                    r_q   <= '0;
                    m_q   <= M0;
                    if (mode_i) begin
                        x_q          <= 32'(a_bi);
                        operationALU <= OP_SUB;
                        argA         <= 32'(a_bi);
                        argB         <= 32'(M0);
                    end else begin
                        argB <= pp(a_bi, 5'd0);
                    end
                end
                SQ_A: begin
                    if (cnt_q == LAST_SQ) begin
                        a2_q  <= resALU;
                        cnt_q <= '0;
                        argB  <= pp(b_q, 5'd0);
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        argA  <= resALU;
                        argB  <= pp(a_q, cnt_q + 5'd1);
                    end
                end
                SQ_B: begin
                    if (cnt_q == LAST_SQ) begin
                        cnt_q <= '0;
                        argA  <= a2_q;
                        argB  <= resALU;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        argA  <= resALU;
                        argB  <= pp(b_q, cnt_q + 5'd1);
                    end
                end
                SUM: begin
                    x_q          <= resALU;
                    operationALU <= OP_SUB;
                    argA         <= resALU;
                    argB         <= 32'(M0);
                end
                SQRT: begin
                    x_q   <= x_n;
                    r_q   <= r_n;
                    m_q   <= m_n;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_RT) begin
                        c_bo <= c_fin;
                    end else begin
                        operationALU <= OP_SUB;
                        argA         <= x_n;
                        argB         <= 32'(r_n) | 32'(m_n);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hypot_alu_param.sv
// Directed bench for hypot_alu_param (WIDTH=8) with a behavioural core ALU.
module tb_hypot_alu_param;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst, start, mode;
    logic [W-1:0]  a_in, b_in;
    logic [31:0]   res_alu, arg_a, arg_b;
    logic [2:0]    op_alu;
    logic [W:0]    c_out;
    logic          busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign res_alu = (op_alu == 3'b100) ? arg_a - arg_b : arg_a + arg_b;

    hypot_alu_param #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .a_bi(a_in), .b_bi(b_in), .resALU(res_alu),
        .operationALU(op_alu), .argA(arg_a), .argB(arg_b),
        .c_bo(c_out), .busy_o(busy), .done_o(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected ALU port contents for busy cycle c of a run.
    function automatic int alu_bad(input logic md, input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        logic [31:0] ea, eb, op;
        int i;
        logic [W-1:0] v;
        alu_bad = 0;
        if (arg_a[31:2*W+1] != 0 || arg_b[31:2*W+1] != 0) alu_bad = 1;
        if (md == 1'b0) begin
            if (c <= 2*W) begin
                v  = (c <= W) ? a : b;
                i  = (c <= W) ? c - 1 : c - W - 1;
                ea = 32'(v) * 32'(v & W'((1 << i) - 1));
                eb = v[i] ? (32'(v) << i) : 32'd0;
                if (op_alu !== 3'b000 || arg_a !== ea || arg_b !== eb) alu_bad = 1;
            end else if (c == 2*W + 1) begin
                if (op_alu !== 3'b000 || arg_a !== 32'(a) * 32'(a) || arg_b !== 32'(b) * 32'(b)) alu_bad = 1;
            end else if (c <= 3*W + 2) begin
                op = 32'(op_alu);
                if (op !== 32'd4) alu_bad = 1;
                if (c == 2*W + 2 && (arg_a !== 32'(a) * 32'(a) + 32'(b) * 32'(b) || arg_b !== 32'h10000)) alu_bad = 1;
            end else if (op_alu !== 3'b000 || arg_a !== 0 || arg_b !== 0) alu_bad = 1;
        end else begin
            if (c <= W + 1) begin
                if (op_alu !== 3'b100) alu_bad = 1;
                if (c == 1 && (arg_a !== 32'(a) || arg_b !== 32'h10000)) alu_bad = 1;
            end else if (op_alu !== 3'b000 || arg_a !== 0 || arg_b !== 0) alu_bad = 1;
        end
    endfunction

    task automatic run(input string tag, input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int ef, input int er);
        int lat, exp_lat, bad, ec;
`ifdef HYPOT_ROUND_EN
        ec = er;
`else
        ec = ef;
`endif
        exp_lat = md ? W + 2 : 3*W + 3;
        @(posedge clk); #1;
        start = 1'b1; mode = md; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bad = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (!busy) bad++;
            bad += alu_bad(md, a, b, c);
            if (done) begin
                lat = c;
                check({tag, "_c"}, 32'(c_out), 32'(ec));
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_alu"}, bad, 0);
        @(negedge clk);
        check({tag, "_idle"}, {busy, done}, 0);
    endtask

    initial begin
        int d1, d2, ndone;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {c_out, busy, done, op_alu}, 0);
        check("rst_args", arg_a | arg_b, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {busy, done}, 0);

        run("h3_4",    1'b0, 8'd3,   8'd4,   5,   5);
        run("h255",    1'b0, 8'd255, 8'd255, 360, 361);
        run("h0",      1'b0, 8'd0,   8'd0,   0,   0);
        run("h5_12",   1'b0, 8'd5,   8'd12,  13,  13);
        run("h1_1",    1'b0, 8'd1,   8'd1,   1,   1);
        run("h255_0",  1'b0, 8'd255, 8'd0,   255, 255);
        run("s200",    1'b1, 8'd200, 8'd77,  14,  14);
        run("s255",    1'b1, 8'd255, 8'd0,   15,  16);
        run("s0",      1'b1, 8'd0,   8'd0,   0,   0);
        run("s3",      1'b1, 8'd3,   8'd0,   1,   2);

        // start held high: new operands appear while busy, accepted only after DONE
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; a_in = 8'd3; b_in = 8'd4;
        @(posedge clk); #1;
        a_in = 8'd5; b_in = 8'd12;
        d1 = 0; d2 = 0; ndone = 0;
        for (int c = 1; c <= 80 && d2 == 0; c++) begin
            @(negedge clk);
            if (c == 28) check("hold_gap", busy, 0);
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = c; check("hold_c1", 32'(c_out), 5); end
                else begin d2 = c; start = 1'b0; check("hold_c2", 32'(c_out), 13); end
            end
        end
        check("hold_d1", d1, 27);
        check("hold_d2", d2, 55);

        // asynchronous reset in cycle 12 of a run
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; a_in = 8'd255; b_in = 8'd255;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out", {c_out, busy, done, op_alu}, 0);
        check("arst_args", arg_a | arg_b, 0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("arst_quiet", ndone, 0);
        run("after_rst", 1'b0, 8'd3, 8'd4, 5, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
